// File: rtl/cache_pkg.sv
// Shared definitions for the N-way write-back cache: controller states, widths
// and the word-select helper used on the 128-bit block.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COMP  = 2'd1,
    S_WRITE = 2'd2,
    S_ALLOC = 2'd3
  } state_e;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int MADDR_W = 28;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0] sel);
    return blk[{sel, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker: one age per way per set, age 0 = MRU, age WAYS-1 = LRU.
// Ages are always a permutation of 0..WAYS-1 within a set.
module cache_lru #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 6,
  parameter int WAY_BITS = 1
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [SET_BITS-1:0] i_set,
  input  logic [WAY_BITS-1:0] i_way,
  input  logic                i_touch,
  output logic [WAY_BITS-1:0] o_lru_way
);

  localparam int SETS = 1 << SET_BITS;

  logic [WAY_BITS-1:0] r_age [SETS][WAYS];
  logic [WAY_BITS-1:0] w_old_age;

  assign w_old_age = r_age[i_set][i_way];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= WAY_BITS'(w);
    end else if (i_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == i_way)
          r_age[i_set][w] <= '0;
        else if (r_age[i_set][w] < w_old_age)
          r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns o_lru_way and no latch is inferred.
    o_lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_age[i_set][w] == WAY_BITS'(WAYS - 1))
        o_lru_way = WAY_BITS'(w);
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate cache with true-LRU victim choice.
// Optional perf counters (hit/miss/write-back) are built when CACHE_PERF_CNT_EN is defined.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 6
) (
  input  logic                clk,
  input  logic                proc_reset,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [29:0]         proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  output logic                mem_read,
  output logic                mem_write,
  output logic [27:0]         mem_addr,
  output logic [BLOCK_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0]  mem_rdata,
  input  logic                mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hit_cnt,
  output logic [31:0]         perf_miss_cnt,
  output logic [31:0]         perf_wb_cnt
`endif
);

  localparam int TAG_W    = MADDR_W - SET_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS     = 1 << SET_BITS;

  state_e              r_state;
  logic                r_valid [WAYS][SETS];
  logic                r_dirty [WAYS][SETS];
  logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
  logic [BLOCK_W-1:0]  r_data  [WAYS][SETS];
  logic [WAY_BITS-1:0] r_victim;

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_word;
  logic                w_req;
  logic [WAYS-1:0]     w_way_hit;
  logic                w_hit;
  logic                w_miss;
  logic [WAY_BITS-1:0] w_hit_way;
  logic [WAY_BITS-1:0] w_victim;
  logic [WAY_BITS-1:0] w_lru_way;

  assign w_index = proc_addr[SET_BITS+1:2];
  assign w_tag   = proc_addr[29:30-TAG_W];
  assign w_word  = proc_addr[1:0];
  assign w_req   = proc_read | proc_write;

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign w_way_hit[g] = r_valid[g][w_index] && (r_tag[g][w_index] == w_tag);
  end

  assign w_hit  = (r_state == S_COMP) && w_req && (|w_way_hit);
  assign w_miss = (r_state == S_COMP) && w_req && !(|w_way_hit);

  // Tags are unique within a set, so at most one way matches.
  always_comb begin
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (w_way_hit[w]) w_hit_way = WAY_BITS'(w);
  end

  // Lowest-index empty way beats the LRU way.
  always_comb begin
    w_victim = w_lru_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w][w_index]) w_victim = WAY_BITS'(w);
  end

  cache_lru #(
    .WAYS     (WAYS),
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .clk       (clk),
    .i_reset   (proc_reset),
    .i_set     (w_index),
    .i_way     (w_hit_way),
    .i_touch   (w_hit),
    .o_lru_way (w_lru_way)
  );

  assign proc_stall = !((r_state == S_COMP) && !w_miss);
  assign proc_rdata = w_hit ? get_word(r_data[w_hit_way][w_index], w_word) : '0;
  assign mem_read   = (r_state == S_ALLOC) && !mem_ready;
  assign mem_write  = (r_state == S_WRITE) && !mem_ready;
  assign mem_addr   = (r_state == S_WRITE) ? {r_tag[r_victim][w_index], w_index}
                                           : proc_addr[29:2];
  assign mem_wdata  = r_data[r_victim][w_index];

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state  <= S_IDLE;
      r_victim <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
        end
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_COMP;
        S_COMP: begin
          if (w_miss) begin
            r_victim <= w_victim;
            r_state  <= (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index])
                        ? S_WRITE : S_ALLOC;
          end else if (w_hit && proc_write) begin
            r_dirty[w_hit_way][w_index] <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_dirty[r_victim][w_index] <= 1'b0;
            r_state                    <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          if (mem_ready) begin
            r_valid[r_victim][w_index] <= 1'b1;
            r_dirty[r_victim][w_index] <= 1'b0;
            r_state                    <= S_COMP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits make their contents
  // irrelevant until a fill, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (w_hit && proc_write)
        r_data[w_hit_way][w_index][{w_word, 5'b0} +: WORD_W] <= proc_wdata;
      if ((r_state == S_ALLOC) && mem_ready) begin
        r_data[r_victim][w_index] <= mem_rdata;
        r_tag[r_victim][w_index]  <= w_tag;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      if ((r_state == S_WRITE) && mem_ready && (r_wb_cnt != '1))
        r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign perf_hit_cnt  = r_hit_cnt;
  assign perf_miss_cnt = r_miss_cnt;
  assign perf_wb_cnt   = r_wb_cnt;
`endif

endmodule
